// File: rtl/uart_boot_ctrl.sv
// uart_boot_ctrl: assembles little-endian 32-bit words from a UART byte
// stream and writes them to consecutive ICCM word addresses. The stream ends
// with END_MARKER, which releases the core from reset.
// Optional build macro: UART_BOOT_CHECKSUM_EN. When it is defined, the word
// after END_MARKER must equal the mod-2^32 sum of all written words.
module uart_boot_ctrl #(
  parameter int unsigned ADDR_W     = 13,
  parameter logic [31:0] END_MARKER = 32'h0000_0FFF
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              core_rst_l,
  output logic              prog_done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;

  localparam logic [1:0]        ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0]        ERR_ADDR_FULL = 2'd2;
`ifdef UART_BOOT_CHECKSUM_EN
  localparam logic [1:0]        ERR_CHECKSUM  = 2'd3;
`endif
  localparam logic [ADDR_W-1:0] ADDR_MAX      = '1;

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         asm_q, asm_d;
  logic                addr_full_q, addr_full_d;
  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [31:0]         mem_wdata_d;
  logic                core_rst_l_d, prog_done_d, err_d;
  logic [1:0]          err_code_d;
  logic                accept;
  logic [31:0]         word;
`ifdef UART_BOOT_CHECKSUM_EN
  logic [31:0]         sum_q, sum_d;
  logic                csum_phase_q, csum_phase_d;
`endif

  // Word completed by the byte arriving now (valid only on the 4th byte).
  assign word = {rx_byte, asm_q};

  // State and output registers; reset clears everything including any pending write.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      addr_full_q  <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_rst_l   <= 1'b0;
      prog_done    <= 1'b0;
      err          <= 1'b0;
      err_code     <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
      sum_q        <= '0;
      csum_phase_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      addr_full_q  <= addr_full_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      core_rst_l   <= core_rst_l_d;
      prog_done    <= prog_done_d;
      err          <= err_d;
      err_code     <= err_code_d;
`ifdef UART_BOOT_CHECKSUM_EN
      sum_q        <= sum_d;
      csum_phase_q <= csum_phase_d;
`endif
    end
  end

  // Next-state logic: byte capture, write completion and word dispatch.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    addr_full_d  = addr_full_q;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    core_rst_l_d = core_rst_l;
    prog_done_d  = prog_done;
    err_d        = err;
    err_code_d   = err_code;
`ifdef UART_BOOT_CHECKSUM_EN
    sum_d        = sum_q;
    csum_phase_d = csum_phase_q;
`endif

    accept = rx_valid && (state_q == IDLE || state_q == RECV || state_q == WRITE);

    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    asm_d[7:0]   = rx_byte;
        2'd1:    asm_d[15:8]  = rx_byte;
        2'd2:    asm_d[23:16] = rx_byte;
        default: asm_d        = '0;
      endcase
    end

    if (state_q == IDLE && rx_valid) state_d = RECV;

    // Write completion runs before dispatch so a word finishing in the same
    // cycle sees the freed output register and the updated address.
    if (state_q == WRITE && mem_ready) begin
      mem_we_d = 1'b0;
      state_d  = RECV;
      if (mem_addr == ADDR_MAX) addr_full_d = 1'b1;
      else                      mem_addr_d  = mem_addr + ADDR_W'(1);
    end

    if (accept && byte_cnt_q == 2'd3) begin
      if (state_q == WRITE && !mem_ready) begin
        state_d    = ERROR;
        mem_we_d   = 1'b0;
        err_d      = 1'b1;
        err_code_d = ERR_OVERFLOW;
      end
`ifdef UART_BOOT_CHECKSUM_EN
      else if (csum_phase_q) begin
        if (word == sum_q) begin
          state_d      = DONE;
          prog_done_d  = 1'b1;
          core_rst_l_d = 1'b1;
        end else begin
          state_d    = ERROR;
          err_d      = 1'b1;
          err_code_d = ERR_CHECKSUM;
        end
      end
`endif
      else if (word == END_MARKER) begin
`ifdef UART_BOOT_CHECKSUM_EN
        csum_phase_d = 1'b1;
`else
        state_d      = DONE;
        prog_done_d  = 1'b1;
        core_rst_l_d = 1'b1;
`endif
      end else if (addr_full_d) begin
        state_d    = ERROR;
        mem_we_d   = 1'b0;
        err_d      = 1'b1;
        err_code_d = ERR_ADDR_FULL;
      end else begin
        state_d     = WRITE;
        mem_we_d    = 1'b1;
        mem_wdata_d = word;
`ifdef UART_BOOT_CHECKSUM_EN
        sum_d       = sum_q + word;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Testbench for uart_boot_ctrl: directed load/stall/overflow/reset cases plus
// randomized images checked against a word-level reference model.
module tb_uart_boot_ctrl;

  localparam logic [31:0] END_MARKER = 32'h0000_0FFF;
`ifdef UART_BOOT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        rx_valid_m = 1'b0, rx_valid_s = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        mem_ready = 1'b0;
  logic        sel_small = 1'b0;

  logic        we_m, crst_m, done_m, err_m;
  logic [12:0] addr_m;
  logic [31:0] data_m;
  logic [1:0]  code_m;
  logic        we_s, crst_s, done_s, err_s;
  logic [1:0]  addr_s;
  logic [31:0] data_s;
  logic [1:0]  code_s;

  logic [31:0] cur_we, cur_addr, cur_data, cur_crst, cur_done, cur_err, cur_code;

  logic [7:0]  stream[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] got_addr[$], got_data[$];
  logic [31:0] exp_done, exp_code;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_boot_ctrl dut_m (
    .clk(clk), .rst_l(rst_l), .rx_valid(rx_valid_m), .rx_byte(rx_byte),
    .mem_we(we_m), .mem_addr(addr_m), .mem_wdata(data_m), .mem_ready(mem_ready),
    .core_rst_l(crst_m), .prog_done(done_m), .err(err_m), .err_code(code_m)
  );

  uart_boot_ctrl #(.ADDR_W(2)) dut_s (
    .clk(clk), .rst_l(rst_l), .rx_valid(rx_valid_s), .rx_byte(rx_byte),
    .mem_we(we_s), .mem_addr(addr_s), .mem_wdata(data_s), .mem_ready(mem_ready),
    .core_rst_l(crst_s), .prog_done(done_s), .err(err_s), .err_code(code_s)
  );

  assign cur_we   = 32'(sel_small ? we_s   : we_m);
  assign cur_addr = sel_small ? 32'(addr_s) : 32'(addr_m);
  assign cur_data = sel_small ? data_s : data_m;
  assign cur_crst = 32'(sel_small ? crst_s : crst_m);
  assign cur_done = 32'(sel_small ? done_s : done_m);
  assign cur_err  = 32'(sel_small ? err_s  : err_m);
  assign cur_code = 32'(sel_small ? code_s : code_m);

  // Record every accepted write (mem_we and mem_ready both high at the next edge).
  always @(negedge clk) begin
    if (rst_l && cur_we[0] && mem_ready) begin
      got_addr.push_back(cur_addr);
      got_data.push_back(cur_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input bit v, input logic [7:0] b, input bit r);
    @(posedge clk); #1;
    rx_byte    = b;
    mem_ready  = r;
    rx_valid_m = v && !sel_small;
    rx_valid_s = v && sel_small;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_l = 1'b0; rx_valid_m = 1'b0; rx_valid_s = 1'b0; mem_ready = 1'b0; rx_byte = '0;
    #1;
    check("rst_we",    cur_we,   32'd0);
    check("rst_addr",  cur_addr, 32'd0);
    check("rst_wdata", cur_data, 32'd0);
    check("rst_crst",  cur_crst, 32'd0);
    check("rst_done",  cur_done, 32'd0);
    check("rst_err",   cur_err,  32'd0);
    check("rst_code",  cur_code, 32'd0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int n = 0; n < 4; n++) stream.push_back(w[8*n +: 8]);
  endtask

  // Word-level model: split the byte stream into words and apply the load rules.
  task automatic ref_model(input int aw);
    logic [31:0] w, sum;
    int n, cap, st;
    bit phase;
    exp_addr.delete(); exp_data.delete();
    exp_done = 0; exp_code = 0;
    cap = 1 << aw; sum = 0; phase = 0; n = 0; st = 0;
    for (int i = 0; i + 3 < stream.size() && st == 0; i += 4) begin
      w = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
      if (phase) begin
        if (w == sum) exp_done = 1; else exp_code = 3;
        st = 1;
      end else if (w == END_MARKER) begin
        if (CSUM) phase = 1;
        else begin exp_done = 1; st = 1; end
      end else if (n == cap) begin
        exp_code = 2; st = 1;
      end else begin
        exp_addr.push_back(32'(n)); exp_data.push_back(w);
        sum += w; n++;
      end
    end
  endtask

  // Drive the stream with random gaps; ready lows never exceed two cycles so a
  // pending write always completes before the next word does.
  task automatic run_stream(input bit rand_ready);
    int lowrun, gap;
    bit r;
    lowrun = 0;
    foreach (stream[i]) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g <= gap; g++) begin
        if (rand_ready) begin
          r = ($urandom_range(0, 1) == 1) || (lowrun >= 2);
          lowrun = r ? 0 : lowrun + 1;
        end else r = 1'b1;
        tick(g == gap, stream[i], r);
      end
    end
    repeat (8) tick(1'b0, 8'h00, 1'b1);
  endtask

  task automatic check_final(input string tag);
    @(negedge clk);
    check({tag, "_nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
    check({tag, "_done"}, cur_done, exp_done);
    check({tag, "_crst"}, cur_crst, exp_done);
    check({tag, "_err"},  cur_err,  32'(exp_code != 0));
    check({tag, "_code"}, cur_code, exp_code);
  endtask

  task automatic build_random(input int nwords, input bit good, input int extra, input bit trunc);
    logic [31:0] w, sum;
    int cut;
    stream.delete(); sum = 0;
    for (int k = 0; k < nwords; k++) begin
      w = $urandom; push_word(w); sum += w;
    end
    push_word(END_MARKER);
    push_word(good ? sum : sum + 32'd1);
    for (int k = 0; k < extra; k++) stream.push_back(8'($urandom));
    if (trunc) begin
      cut = $urandom_range(1, stream.size() - 1);
      repeat (cut) void'(stream.pop_back());
    end
  endtask

  task automatic build_basic();
    stream.delete();
    push_word(32'h0000_3713);
    push_word(32'hDEAD_BEEF);
    push_word(END_MARKER);
    if (CSUM) push_word(32'hDEAD_F602);
  endtask

  initial begin
    logic [7:0] b40 [3] = '{8'hEF, 8'hBE, 8'hAD};

    // Basic image with memory always ready.
    sel_small = 1'b0;
    do_reset();
    build_basic();
    run_stream(1'b0);
    ref_model(13);
    check_final("basic");
    check("basic_n", 32'(got_data.size()), 32'd2);
    if (got_data.size() >= 2) begin
      check("basic_a0", got_addr[0], 32'd0);
      check("basic_d0", got_data[0], 32'h0000_3713);
      check("basic_a1", got_addr[1], 32'd1);
      check("basic_d1", got_data[1], 32'hDEAD_BEEF);
    end
    check("basic_done", cur_done, 32'd1);

    // First write stalled 20 cycles; next word buffers, its last byte meets mem_ready.
    do_reset();
    tick(1'b1, 8'h13, 1'b0); tick(1'b1, 8'h37, 1'b0);
    tick(1'b1, 8'h00, 1'b0); tick(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i >= 2 && i <= 4) tick(1'b1, b40[i-2], 1'b0);
      else                  tick(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      check("stall_we",   cur_we,   32'd1);
      check("stall_addr", cur_addr, 32'd0);
      check("stall_data", cur_data, 32'h0000_3713);
      check("stall_err",  cur_err,  32'd0);
    end
    tick(1'b1, 8'hDE, 1'b1);
    tick(1'b1, 8'hFF, 1'b1); tick(1'b1, 8'h0F, 1'b1);
    tick(1'b1, 8'h00, 1'b1); tick(1'b1, 8'h00, 1'b1);
    if (CSUM) begin
      tick(1'b1, 8'h02, 1'b1); tick(1'b1, 8'hF6, 1'b1);
      tick(1'b1, 8'hAD, 1'b1); tick(1'b1, 8'hDE, 1'b1);
    end
    repeat (6) tick(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("stall_n", 32'(got_data.size()), 32'd2);
    if (got_data.size() >= 2) begin
      check("stall_a0", got_addr[0], 32'd0);
      check("stall_d0", got_data[0], 32'h0000_3713);
      check("stall_a1", got_addr[1], 32'd1);
      check("stall_d1", got_data[1], 32'hDEAD_BEEF);
    end
    check("stall_done", cur_done, 32'd1);
    check("stall_crst", cur_crst, 32'd1);
    check("stall_errend", cur_err, 32'd0);

    // Overflow: memory never ready while 8 more bytes arrive.
    do_reset();
    for (int i = 0; i < 12; i++) tick(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    repeat (3) tick(1'b1, 8'h55, 1'b1);
    @(negedge clk);
    check("ovf_err",  cur_err,  32'd1);
    check("ovf_code", cur_code, 32'd1);
    check("ovf_crst", cur_crst, 32'd0);
    check("ovf_done", cur_done, 32'd0);
    check("ovf_we",   cur_we,   32'd0);
    check("ovf_nwr",  32'(got_data.size()), 32'd0);

    // Address-full on the 2-bit address variant: six data words.
    sel_small = 1'b1;
    do_reset();
    stream.delete();
    for (int k = 0; k < 6; k++) push_word(32'h1000_0000 + 32'(k));
    push_word(END_MARKER);
    run_stream(1'b1);
    ref_model(2);
    check_final("full");
    check("full_n",    32'(got_data.size()), 32'd4);
    check("full_code", cur_code, 32'd2);
    check("full_addr", cur_addr, 32'd3);
    sel_small = 1'b0;

    // Reset after two bytes of a word, then a full image.
    do_reset();
    tick(1'b1, 8'hAA, 1'b1); tick(1'b1, 8'hBB, 1'b1); tick(1'b0, 8'h00, 1'b1);
    do_reset();
    build_basic();
    run_stream(1'b1);
    ref_model(13);
    check_final("midrst");
    if (got_data.size() >= 1) begin
      check("midrst_a0", got_addr[0], 32'd0);
      check("midrst_d0", got_data[0], 32'h0000_3713);
    end

    // Reset while a write is pending must drop mem_we immediately.
    do_reset();
    tick(1'b1, 8'h01, 1'b0); tick(1'b1, 8'h02, 1'b0);
    tick(1'b1, 8'h03, 1'b0); tick(1'b1, 8'h04, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("pend_we", cur_we, 32'd1);
    do_reset();
    repeat (4) tick(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("pend_nwr", 32'(got_data.size()), 32'd0);

`ifdef UART_BOOT_CHECKSUM_EN
    do_reset();
    stream.delete();
    push_word(32'd1); push_word(32'd2); push_word(END_MARKER); push_word(32'd3);
    run_stream(1'b1);
    check("csum_ok_done", cur_done, 32'd1);
    check("csum_ok_code", cur_code, 32'd0);
    do_reset();
    stream.delete();
    push_word(32'd1); push_word(32'd2); push_word(END_MARKER); push_word(32'd4);
    run_stream(1'b1);
    check("csum_bad_code", cur_code, 32'd3);
    check("csum_bad_crst", cur_crst, 32'd0);
`endif

    // Randomized images on both address widths.
    for (int it = 0; it < 14; it++) begin
      sel_small = ($urandom_range(0, 1) == 1);
      do_reset();
      build_random($urandom_range(0, 7), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 6), $urandom_range(0, 3) == 0);
      run_stream(1'b1);
      ref_model(sel_small ? 2 : 13);
      check_final($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
